mib_master: RTL

Synthesisable, parametrised MIB command-bus master that replaces testbench-only bus driving in RTL designs. It accepts one read or write request at a time on a valid/ready port and serialises the address and write data onto the shared MIB address/data bus, most-significant beat first. It releases the bus, waits for `slave_ack` with a bounded timeout, and returns read data or a timeout flag on a valid/ready response port. It sits between an on-chip controller (CPU bridge, sequencer) and the MIB pad ring; the pad-level tristate is built outside from `mib_ad_o`/`mib_ad_oe`.

---
 rtl/mib_master.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mib_master.sv
// ============================================================================
// mib_master : valid/ready request port to serial MIB address/data bus master
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mib_master #(
  parameter int ADDR_BITS    = 24,
  parameter int DATA_BITS    = 32,
  parameter int BUS_BITS     = 16,
  parameter int TIMEOUT_CLKS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rd_wr_n,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 mib_start,
  output logic                 mib_rd_wr_n,
  output logic [BUS_BITS-1:0]  mib_ad_o,
  output logic                 mib_ad_oe,
  input  logic [BUS_BITS-1:0]  mib_ad_i,
  input  logic                 mib_slave_ack
);

  localparam int ADDR_BEATS = (ADDR_BITS + BUS_BITS - 1) / BUS_BITS;
  localparam int DATA_BEATS = (DATA_BITS + BUS_BITS - 1) / BUS_BITS;
  localparam int AW_EXT     = ADDR_BEATS * BUS_BITS;
  localparam int DW_EXT     = DATA_BEATS * BUS_BITS;
  localparam int MAX_BEATS  = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
  localparam int BEAT_W     = $clog2(MAX_BEATS + 1);
  localparam int TO_W       = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_WDATA    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RDATA    = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [AW_EXT-1:0]      addr_sh_q, addr_sh_d;
  logic [DW_EXT-1:0]      wdata_sh_q, wdata_sh_d;
  logic [DW_EXT-1:0]      rdata_sh_q, rdata_sh_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   start_q, start_d;
  logic                   rd_wr_n_q, rd_wr_n_d;
  logic [BUS_BITS-1:0]    ad_o_q, ad_o_d;
  logic                   oe_q, oe_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  logic [AW_EXT-1:0]      w_addr_ext;
  logic [DW_EXT-1:0]      w_rdata_next;

  // Beats leave from the top of each shift register, so MS beat goes first.
  assign w_addr_ext   = AW_EXT'(req_addr);
  assign w_rdata_next = (rdata_sh_q << BUS_BITS) | DW_EXT'(mib_ad_i);

  always_comb begin
    state_d       = state_q;
    addr_sh_d     = addr_sh_q;
    wdata_sh_d    = wdata_sh_q;
    rdata_sh_d    = rdata_sh_q;
    beat_d        = beat_q;
    to_cnt_d      = to_cnt_q;
    start_d       = 1'b0;
    rd_wr_n_d     = rd_wr_n_q;
    ad_o_d        = ad_o_q;
    oe_d          = oe_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_ADDR;
          rd_wr_n_d  = req_rd_wr_n;
          ad_o_d     = w_addr_ext[AW_EXT-1 -: BUS_BITS];
          addr_sh_d  = w_addr_ext << BUS_BITS;
          wdata_sh_d = DW_EXT'(req_wdata);
          start_d    = 1'b1;
          oe_d       = 1'b1;
          beat_d     = '0;
        end
      end

      S_ADDR: begin
        if (beat_q == BEAT_W'(ADDR_BEATS - 1)) begin
          beat_d = '0;
          if (rd_wr_n_q) begin
            state_d  = S_WAIT_ACK;
            oe_d     = 1'b0;
            ad_o_d   = '0;
            to_cnt_d = '0;
          end else begin
            state_d    = S_WDATA;
            ad_o_d     = wdata_sh_q[DW_EXT-1 -: BUS_BITS];
            wdata_sh_d = wdata_sh_q << BUS_BITS;
          end
        end else begin
          ad_o_d    = addr_sh_q[AW_EXT-1 -: BUS_BITS];
          addr_sh_d = addr_sh_q << BUS_BITS;
          beat_d    = beat_q + BEAT_W'(1);
        end
      end

      S_WDATA: begin
        if (beat_q == BEAT_W'(DATA_BEATS - 1)) begin
          state_d  = S_WAIT_ACK;
          oe_d     = 1'b0;
          ad_o_d   = '0;
          to_cnt_d = '0;
        end else begin
          ad_o_d     = wdata_sh_q[DW_EXT-1 -: BUS_BITS];
          wdata_sh_d = wdata_sh_q << BUS_BITS;
          beat_d     = beat_q + BEAT_W'(1);
        end
      end

      S_WAIT_ACK: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (mib_slave_ack) begin
          if (!rd_wr_n_q) begin
            state_d       = S_RESP;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b0;
          end else begin
            rdata_sh_d = w_rdata_next;
            beat_d     = '0;
            if (DATA_BEATS == 1) begin
              state_d       = S_RESP;
              rsp_valid_d   = 1'b1;
              rsp_rdata_d   = w_rdata_next[DATA_BITS-1:0];
              rsp_timeout_d = 1'b0;
            end else begin
              state_d = S_RDATA;
            end
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_RDATA: begin
        rdata_sh_d = w_rdata_next;
        if (beat_q == BEAT_W'(DATA_BEATS - 2)) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = w_rdata_next[DATA_BITS-1:0];
          rsp_timeout_d = 1'b0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d       = S_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          rd_wr_n_d     = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_sh_q     <= '0;
      wdata_sh_q    <= '0;
      rdata_sh_q    <= '0;
      beat_q        <= '0;
      to_cnt_q      <= '0;
      start_q       <= 1'b0;
      rd_wr_n_q     <= 1'b1;
      ad_o_q        <= '0;
      oe_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_sh_q     <= addr_sh_d;
      wdata_sh_q    <= wdata_sh_d;
      rdata_sh_q    <= rdata_sh_d;
      beat_q        <= beat_d;
      to_cnt_q      <= to_cnt_d;
      start_q       <= start_d;
      rd_wr_n_q     <= rd_wr_n_d;
      ad_o_q        <= ad_o_d;
      oe_q          <= oe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign mib_start   = start_q;
  assign mib_rd_wr_n = rd_wr_n_q;
  assign mib_ad_o    = ad_o_q;
  assign mib_ad_oe   = oe_q;

endmodule

`default_nettype wire
